// File: rtl/wbu_commit.sv
// Write-back / commit stage: retires one held instruction per cycle, performs GPR/CSR writes,
// and sequences the two-cycle trap (mepc, then mcause) and mret redirects.
module wbu_commit (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [31:0] lsu_pc_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic        lsu_gr_we_i,
  input  logic [31:0] lsu_result_i,
  input  logic        lsu_csr_we_i,
  input  logic [11:0] lsu_csr_addr_i,
  input  logic [31:0] lsu_csr_wdata_i,
  input  logic        lsu_xret_i,
  input  logic [4:0]  lsu_excp_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        wbu_valid_o,
  output logic [4:0]  wbu_rd_o,
  output logic [11:0] wbu_csr_addr_o,
  output logic        excp_flush_o,
  output logic        mret_flush_o,
  output logic [31:0] flush_target_o,
  output logic        retire_o,
  output logic [31:0] retire_pc_o
);

  localparam logic [11:0] CsrMepc   = 12'h341;
  localparam logic [11:0] CsrMcause = 12'h342;

  typedef enum logic [1:0] {StIdle, StCommit, StTrapEpc, StTrapCause} state_e;

  state_e state_q, state_d;

  logic [31:0] pc_q;
  logic [4:0]  rd_q;
  logic        gr_we_q;
  logic [31:0] result_q;
  logic        csr_we_q;
  logic [11:0] csr_addr_q;
  logic [31:0] csr_wdata_q;
  logic        xret_q;
  logic [4:0]  excp_q;

  logic capture;
  logic has_excp;

  assign has_excp    = excp_q[4];
  // Exception or mret in COMMIT redirects the pipeline, so nothing younger may enter.
  assign lsu_ready_o = (state_q == StIdle) ||
                       ((state_q == StCommit) && !has_excp && !xret_q);
  assign capture     = lsu_valid_i && lsu_ready_o;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      rd_q        <= '0;
      gr_we_q     <= 1'b0;
      result_q    <= '0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      xret_q      <= 1'b0;
      excp_q      <= '0;
    end else if (capture) begin
      pc_q        <= lsu_pc_i;
      rd_q        <= lsu_rd_i;
      gr_we_q     <= lsu_gr_we_i;
      result_q    <= lsu_result_i;
      csr_we_q    <= lsu_csr_we_i;
      csr_addr_q  <= lsu_csr_addr_i;
      csr_wdata_q <= lsu_csr_wdata_i;
      xret_q      <= lsu_xret_i;
      excp_q      <= lsu_excp_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      state_d = capture ? StCommit : StIdle;
      StCommit: begin
        if (has_excp)    state_d = StTrapEpc;
        else if (xret_q) state_d = StIdle;
        else             state_d = capture ? StCommit : StIdle;
      end
      StTrapEpc:   state_d = StTrapCause;
      StTrapCause: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;
    csr_we_o       = 1'b0;
    csr_waddr_o    = '0;
    csr_wdata_o    = '0;
    excp_flush_o   = 1'b0;
    mret_flush_o   = 1'b0;
    flush_target_o = '0;
    retire_o       = 1'b0;
    retire_pc_o    = '0;
    wbu_valid_o    = (state_q != StIdle);
    wbu_rd_o       = (wbu_valid_o && gr_we_q) ? rd_q : 5'd0;
    wbu_csr_addr_o = '0;
    unique case (state_q)
      StIdle: ;
      StCommit: begin
        if (csr_we_q) wbu_csr_addr_o = csr_addr_q;
        if (!has_excp) begin
          rf_we_o     = gr_we_q && (rd_q != 5'd0);
          rf_waddr_o  = rd_q;
          rf_wdata_o  = result_q;
          csr_we_o    = csr_we_q;
          csr_waddr_o = csr_addr_q;
          csr_wdata_o = csr_wdata_q;
          retire_o    = 1'b1;
          retire_pc_o = pc_q;
          if (xret_q) begin
            mret_flush_o   = 1'b1;
            flush_target_o = mepc_i;
          end
        end
      end
      StTrapEpc: begin
        wbu_csr_addr_o = CsrMepc;
        csr_we_o       = 1'b1;
        csr_waddr_o    = CsrMepc;
        csr_wdata_o    = pc_q;
      end
      StTrapCause: begin
        wbu_csr_addr_o = CsrMcause;
        csr_we_o       = 1'b1;
        csr_waddr_o    = CsrMcause;
        csr_wdata_o    = {28'b0, excp_q[3:0]};
        excp_flush_o   = 1'b1;
        flush_target_o = mtvec_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wbu_commit.sv
// Bench for wbu_commit: table of back-to-back commits checked through a retire scoreboard,
// plus hand-written trap, mret and mid-trap asynchronous reset sequences.
module tb_wbu_commit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [31:0] lsu_pc_i;
  logic [4:0]  lsu_rd_i;
  logic        lsu_gr_we_i;
  logic [31:0] lsu_result_i;
  logic        lsu_csr_we_i;
  logic [11:0] lsu_csr_addr_i;
  logic [31:0] lsu_csr_wdata_i;
  logic        lsu_xret_i;
  logic [4:0]  lsu_excp_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        wbu_valid_o;
  logic [4:0]  wbu_rd_o;
  logic [11:0] wbu_csr_addr_o;
  logic        excp_flush_o;
  logic        mret_flush_o;
  logic [31:0] flush_target_o;
  logic        retire_o;
  logic [31:0] retire_pc_o;

  always #5 clock = ~clock;

  wbu_commit dut (
    .clock          (clock),
    .reset          (reset),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_ready_o    (lsu_ready_o),
    .lsu_pc_i       (lsu_pc_i),
    .lsu_rd_i       (lsu_rd_i),
    .lsu_gr_we_i    (lsu_gr_we_i),
    .lsu_result_i   (lsu_result_i),
    .lsu_csr_we_i   (lsu_csr_we_i),
    .lsu_csr_addr_i (lsu_csr_addr_i),
    .lsu_csr_wdata_i(lsu_csr_wdata_i),
    .lsu_xret_i     (lsu_xret_i),
    .lsu_excp_i     (lsu_excp_i),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .csr_we_o       (csr_we_o),
    .csr_waddr_o    (csr_waddr_o),
    .csr_wdata_o    (csr_wdata_o),
    .mtvec_i        (mtvec_i),
    .mepc_i         (mepc_i),
    .wbu_valid_o    (wbu_valid_o),
    .wbu_rd_o       (wbu_rd_o),
    .wbu_csr_addr_o (wbu_csr_addr_o),
    .excp_flush_o   (excp_flush_o),
    .mret_flush_o   (mret_flush_o),
    .flush_target_o (flush_target_o),
    .retire_o       (retire_o),
    .retire_pc_o    (retire_pc_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        gr_we;
    logic [31:0] result;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        exp_rf_we;
    logic        exp_csr_we;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  vec_t exp_q[$];
  vec_t mv;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic xret, input logic [4:0] excp);
    lsu_valid_i     = 1'b1;
    lsu_pc_i        = v.pc;
    lsu_rd_i        = v.rd;
    lsu_gr_we_i     = v.gr_we;
    lsu_result_i    = v.result;
    lsu_csr_we_i    = v.csr_we;
    lsu_csr_addr_i  = v.csr_addr;
    lsu_csr_wdata_i = v.csr_wdata;
    lsu_xret_i      = xret;
    lsu_excp_i      = excp;
  endtask

  task automatic idle_inputs();
    lsu_valid_i     = 1'b0;
    lsu_pc_i        = '0;
    lsu_rd_i        = '0;
    lsu_gr_we_i     = 1'b0;
    lsu_result_i    = '0;
    lsu_csr_we_i    = 1'b0;
    lsu_csr_addr_i  = '0;
    lsu_csr_wdata_i = '0;
    lsu_xret_i      = 1'b0;
    lsu_excp_i      = '0;
  endtask

  // Retire scoreboard: each retirement must match the oldest accepted instruction.
  always @(negedge clock) begin
    if (mon_en && retire_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL retire_unexpected: got pc %h want none", retire_pc_o);
      end else begin
        mv = exp_q.pop_front();
        chk("retire_pc", retire_pc_o, mv.pc);
        chk("rf_we", 32'(rf_we_o), 32'(mv.exp_rf_we));
        if (mv.exp_rf_we) begin
          chk("rf_waddr", 32'(rf_waddr_o), 32'(mv.rd));
          chk("rf_wdata", rf_wdata_o, mv.result);
        end
        chk("csr_we", 32'(csr_we_o), 32'(mv.exp_csr_we));
        if (mv.exp_csr_we) begin
          chk("csr_waddr", 32'(csr_waddr_o), 32'(mv.csr_addr));
          chk("csr_wdata", csr_wdata_o, mv.csr_wdata);
        end
        chk("wbu_valid", 32'(wbu_valid_o), 32'd1);
        chk("wbu_rd", 32'(wbu_rd_o), mv.gr_we ? 32'(mv.rd) : 32'd0);
        chk("wbu_csr_addr", 32'(wbu_csr_addr_o), mv.csr_we ? 32'(mv.csr_addr) : 32'd0);
      end
    end
  end

  vec_t tv;

  initial begin
    tbl[0] = '{32'h0000_1000, 5'd5,  1'b1, 32'h0000_000A, 1'b0, 12'h000, 32'h0,          1'b1, 1'b0};
    tbl[1] = '{32'h0000_1004, 5'd6,  1'b1, 32'h0000_000B, 1'b0, 12'h000, 32'h0,          1'b1, 1'b0};
    tbl[2] = '{32'h0000_1008, 5'd0,  1'b1, 32'hFFFF_FFFF, 1'b0, 12'h000, 32'h0,          1'b0, 1'b0};
    tbl[3] = '{32'h0000_100C, 5'd7,  1'b0, 32'h0000_0123, 1'b0, 12'h000, 32'h0,          1'b0, 1'b0};
    tbl[4] = '{32'h0000_1010, 5'd8,  1'b0, 32'h0,         1'b1, 12'h300, 32'h0000_1888,  1'b0, 1'b1};
    tbl[5] = '{32'h0000_1014, 5'd31, 1'b1, 32'hDEAD_BEEF, 1'b1, 12'h305, 32'h8000_0100, 1'b1, 1'b1};
    tbl[6] = '{32'h0000_1018, 5'd1,  1'b1, 32'h0000_5A5A, 1'b0, 12'h000, 32'h0,          1'b1, 1'b0};

    idle_inputs();
    mtvec_i = 32'h8000_0100;
    mepc_i  = 32'h8000_0040;

    // Reset state, with a valid instruction offered to show nothing is captured.
    lsu_valid_i = 1'b1;
    #12;
    chk("rst_ready", 32'(lsu_ready_o), 32'd1);
    chk("rst_rf_we", 32'(rf_we_o), 32'd0);
    chk("rst_csr_we", 32'(csr_we_o), 32'd0);
    chk("rst_retire", 32'(retire_o), 32'd0);
    chk("rst_wbu_valid", 32'(wbu_valid_o), 32'd0);
    chk("rst_excp_flush", 32'(excp_flush_o), 32'd0);
    chk("rst_mret_flush", 32'(mret_flush_o), 32'd0);
    chk("rst_target", flush_target_o, 32'd0);
    idle_inputs();
    @(negedge clock);
    reset = 1'b1;
    mon_en = 1'b1;

    // Back-to-back table: one instruction per cycle, ready must stay high.
    for (int i = 0; i < 7; i++) begin
      @(posedge clock);
      #1;
      drive(tbl[i], 1'b0, 5'd0);
      exp_q.push_back(tbl[i]);
      @(negedge clock);
      chk("ready_b2b", 32'(lsu_ready_o), 32'd1);
    end
    @(posedge clock);
    #1;
    idle_inputs();
    @(posedge clock);
    @(negedge clock);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("idle_wbu_valid", 32'(wbu_valid_o), 32'd0);
    chk("idle_retire", 32'(retire_o), 32'd0);
    mon_en = 1'b0;

    // Trap: held gr/csr writes must be suppressed, then mepc, then mcause + flush.
    tv = '{32'h8000_0010, 5'd9, 1'b1, 32'h1111, 1'b1, 12'h300, 32'h2222, 1'b0, 1'b0};
    @(posedge clock);
    #1;
    drive(tv, 1'b0, 5'b1_0010);
    @(posedge clock);
    #1;
    idle_inputs();
    @(negedge clock);
    chk("trap_c1_rf_we", 32'(rf_we_o), 32'd0);
    chk("trap_c1_csr_we", 32'(csr_we_o), 32'd0);
    chk("trap_c1_retire", 32'(retire_o), 32'd0);
    chk("trap_c1_ready", 32'(lsu_ready_o), 32'd0);
    chk("trap_c1_flush", 32'(excp_flush_o), 32'd0);
    @(negedge clock);
    chk("trap_c2_csr_we", 32'(csr_we_o), 32'd1);
    chk("trap_c2_waddr", 32'(csr_waddr_o), 32'h341);
    chk("trap_c2_wdata", csr_wdata_o, 32'h8000_0010);
    chk("trap_c2_rf_we", 32'(rf_we_o), 32'd0);
    chk("trap_c2_ready", 32'(lsu_ready_o), 32'd0);
    chk("trap_c2_flush", 32'(excp_flush_o), 32'd0);
    chk("trap_c2_hazard", 32'(wbu_csr_addr_o), 32'h341);
    @(negedge clock);
    chk("trap_c3_csr_we", 32'(csr_we_o), 32'd1);
    chk("trap_c3_waddr", 32'(csr_waddr_o), 32'h342);
    chk("trap_c3_wdata", csr_wdata_o, 32'h0000_0002);
    chk("trap_c3_flush", 32'(excp_flush_o), 32'd1);
    chk("trap_c3_target", flush_target_o, 32'h8000_0100);
    chk("trap_c3_rf_we", 32'(rf_we_o), 32'd0);
    chk("trap_c3_ready", 32'(lsu_ready_o), 32'd0);
    @(negedge clock);
    chk("trap_c4_flush", 32'(excp_flush_o), 32'd0);
    chk("trap_c4_target", flush_target_o, 32'd0);
    chk("trap_c4_csr_we", 32'(csr_we_o), 32'd0);
    chk("trap_c4_ready", 32'(lsu_ready_o), 32'd1);

    // mret with valid held high: the follower is not taken during the flush cycle.
    tv = '{32'h0000_3000, 5'd0, 1'b0, 32'h0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0};
    @(posedge clock);
    #1;
    drive(tv, 1'b1, 5'd0);
    @(posedge clock);
    #1;
    tv = '{32'h0000_3004, 5'd11, 1'b1, 32'h77, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
    drive(tv, 1'b0, 5'd0);
    @(negedge clock);
    chk("mret_flush", 32'(mret_flush_o), 32'd1);
    chk("mret_target", flush_target_o, 32'h8000_0040);
    chk("mret_ready", 32'(lsu_ready_o), 32'd0);
    chk("mret_excp_flush", 32'(excp_flush_o), 32'd0);
    @(negedge clock);
    chk("mret_once", 32'(mret_flush_o), 32'd0);
    chk("mret_target_clr", flush_target_o, 32'd0);
    chk("mret_not_taken", 32'(wbu_valid_o), 32'd0);
    @(posedge clock);
    #1;
    idle_inputs();
    @(negedge clock);
    chk("post_mret_retire", 32'(retire_o), 32'd1);
    chk("post_mret_pc", retire_pc_o, 32'h0000_3004);
    chk("post_mret_rf_we", 32'(rf_we_o), 32'd1);
    chk("post_mret_waddr", 32'(rf_waddr_o), 32'd11);
    chk("post_mret_wdata", rf_wdata_o, 32'h77);

    // Asynchronous reset in the middle of TRAP_EPC.
    tv = '{32'h8000_0020, 5'd3, 1'b1, 32'h0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0};
    @(posedge clock);
    #1;
    drive(tv, 1'b0, 5'b1_0101);
    @(posedge clock);
    #1;
    idle_inputs();
    @(posedge clock);
    #3;
    chk("arst_in_epc", 32'(csr_waddr_o), 32'h341);
    reset = 1'b0;
    #1;
    chk("arst_csr_we", 32'(csr_we_o), 32'd0);
    chk("arst_wbu_valid", 32'(wbu_valid_o), 32'd0);
    chk("arst_ready", 32'(lsu_ready_o), 32'd1);
    @(posedge clock);
    #1;
    chk("arst_no_mcause", 32'(csr_we_o), 32'd0);
    chk("arst_no_flush", 32'(excp_flush_o), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("arst_after_csr_we", 32'(csr_we_o), 32'd0);
    chk("arst_after_flush", 32'(excp_flush_o), 32'd0);
    chk("arst_after_target", flush_target_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
